// File: rtl/inst_rom_ctrl_pkg.sv
// rtl/inst_rom_ctrl_pkg.sv - shared constants, FSM encoding and boot image for the instruction ROM controller
package inst_rom_ctrl_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int WAIT_CNT_W      = 4;

  localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Boot program compiled into the array; words beyond the listed ones read as zero (NOP).
  function automatic logic [INST_BUS_W-1:0] boot_word(input int unsigned idx);
    case (idx)
      32'd0:   boot_word = 32'h3401_1100;  // ori $1, $0, 0x1100
      32'd1:   boot_word = 32'h3402_0020;  // ori $2, $0, 0x0020
      default: boot_word = ZERO_WORD;
    endcase
  endfunction

endpackage

// File: rtl/inst_rom_ctrl_rom_array.sv
// rtl/inst_rom_ctrl_rom_array.sv - preloaded read-only word array with a registered read port
import inst_rom_ctrl_pkg::*;

module rom_array #(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    DATA_WIDTH = INST_BUS_W,
  parameter string INIT_FILE  = "inst_rom.data"
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // An empty image name leaves the array blank; otherwise the boot image is loaded.
  localparam bit HAS_IMAGE = (INIT_FILE != "");

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_image
    assign mem[i] = HAS_IMAGE ? DATA_WIDTH'(boot_word(i)) : '0;
  end

  // Registered read; the data register only moves when the controller launches a fetch.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_rom_ctrl.sv
// rtl/inst_rom_ctrl.sv - req/ack instruction memory controller with wait states, error flags and abort
import inst_rom_ctrl_pkg::*;

module inst_rom_ctrl #(
  parameter int    ADDR_WIDTH  = INST_ADDR_BUS_W,
  parameter int    DATA_WIDTH  = INST_BUS_W,
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = "inst_rom.data"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    ok_q;
  logic                    err_q;
  logic                    accept;
  logic                    load;
  logic                    abort;
  logic [ADDR_WIDTH-1:0]   fetch_addr;
  logic                    fetch_err;
  logic                    rom_en;
  logic [DATA_WIDTH-1:0]   rom_data;

  // The read is launched on the edge that enters RESP: from the captured address
  // when leaving WAIT, or straight from the accepted address with zero wait states.
  assign fetch_addr = (state_q == ST_WAIT) ? addr_q : addr_i;
  assign fetch_err  = (|fetch_addr[1:0]) | (|fetch_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]);
  assign rom_en     = load & ~fetch_err;

  rom_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .clk     (clk),
    .rd_en   (rom_en),
    .rd_addr (fetch_addr[DEPTH_LOG2+1:2]),
    .rd_data (rom_data)
  );

  // Next-state logic: accept, wait countdown, response and abort on chip-enable drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    load    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ce_i == CHIP_ENABLE && req_i) begin
          accept = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ce_i == CHIP_DISABLE) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          load    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (ce_i == CHIP_DISABLE) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (req_i) begin
          accept = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (WAIT_STATES == 0) begin
        load    = 1'b1;
        state_d = ST_RESP;
      end else begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
    end
  end

  // State, counter, captured address and result flags; the flags gate the ROM data onto inst_o.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= addr_i;
      end
      if (load) begin
        ok_q  <= ~fetch_err;
        err_q <= fetch_err;
      end else if (abort) begin
        ok_q  <= 1'b0;
        err_q <= 1'b0;
      end
    end
  end

  assign ack_o  = (state_q == ST_RESP);
  assign busy_o = (state_q != ST_IDLE);
  assign err_o  = ack_o & err_q;
  assign inst_o = ok_q ? rom_data : '0;

endmodule
